// File: rtl/kmap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kmap_pkg
// Description : Shared types and helpers for the K-map sweep checker.
// Revision    : 1.0 - initial release
// ============================================================================
package kmap_pkg;

  // Width of the settle dwell counter (dwell of 0..255 cycles).
  localparam int SETTLE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } kmap_state_t;

  // Number of rows in the truth table of an n-input function.
  function automatic int n_minterms(input int n);
    return 1 << n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kmap_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : kmap_settle_timer
// Description : Dwell timer for the SETTLE state. load clears the count,
//               count advances it, expire flags the last dwell cycle.
//               With SETTLE_CYCLES == 0 there is no dwell and expire is
//               constantly high.
// Revision    : 1.0 - initial release
// ============================================================================
module kmap_settle_timer
  import kmap_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic areset_n,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  generate
    if (SETTLE_CYCLES == 0) begin : g_no_dwell
      logic unused_w;
      assign unused_w = ^{clk, areset_n, load_i, count_i};
      assign expire_o = 1'b1;
    end else begin : g_dwell
      localparam logic [SETTLE_W-1:0] LAST_CNT = SETTLE_W'(SETTLE_CYCLES - 1);

      logic [SETTLE_W-1:0] cnt_q;
      logic [SETTLE_W-1:0] cnt_d;

      // Next count: restart on load, otherwise step while dwelling.
      always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
          cnt_d = '0;
        end else if (count_i) begin
          cnt_d = cnt_q + SETTLE_W'(1);
        end
      end

      // Count register.
      always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expire_o = count_i && (cnt_q == LAST_CNT);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/kmap_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : kmap_sweep_checker
// Description : Sweeps x_out through every minterm of an N_IN-input
//               combinational function, samples f_in after a settle dwell,
//               builds the captured truth table and compares it against an
//               expected table under a care mask.
//               Optional macro KMAP_SWEEP_FIRST_FAIL_EN adds first_fail_vld /
//               first_fail_idx reporting the lowest failing cared minterm.
// Revision    : 1.0 - initial release
// ============================================================================
module kmap_sweep_checker
  import kmap_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_val,
  input  logic [2**N_IN-1:0]   care_mask,
  output logic [N_IN-1:0]      x_out,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   captured,
  output logic [2**N_IN-1:0]   mismatch
`ifdef KMAP_SWEEP_FIRST_FAIL_EN
  ,
  output logic                 first_fail_vld,
  output logic [N_IN-1:0]      first_fail_idx
`endif
);

  localparam int                NM       = n_minterms(N_IN);
  localparam int                IDX_W    = N_IN + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NM - 1);
  // With no dwell, every step goes straight to SAMPLE.
  localparam kmap_state_t       STEP_ST  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  kmap_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NM-1:0]     exp_q, exp_d;
  logic [NM-1:0]     care_q, care_d;
  logic [NM-1:0]     cap_q, cap_d;
  logic [NM-1:0]     mis_q, mis_d;
  logic              pass_q, pass_d;
  logic              accept_w;
  logic              last_w;
  logic              sample_mis_w;
  logic              expire_w;
  logic              tmr_load_w;
  logic              tmr_count_w;

  assign accept_w     = (state_q == IDLE) && start;
  assign last_w       = (idx_q == LAST_IDX);
  // A don't-care minterm forces this low even if f_in is unknown.
  assign sample_mis_w = care_q[idx_q[N_IN-1:0]] && (f_in != exp_q[idx_q[N_IN-1:0]]);
  assign tmr_load_w   = (state_d == SETTLE) && (state_q != SETTLE);
  assign tmr_count_w  = (state_q == SETTLE);

  kmap_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .areset_n (areset_n),
    .load_i   (tmr_load_w),
    .count_i  (tmr_count_w),
    .expire_o (expire_w)
  );

  // State register.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is honoured only in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = STEP_ST;
      SETTLE:  if (expire_w) state_d = SAMPLE;
      SAMPLE:  state_d = last_w ? DONE : STEP_ST;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch on start, capture/compare on each sample.
  always_comb begin
    idx_d  = idx_q;
    exp_d  = exp_q;
    care_d = care_q;
    cap_d  = cap_q;
    mis_d  = mis_q;
    pass_d = pass_q;
    if (accept_w) begin
      idx_d  = '0;
      exp_d  = exp_val;
      care_d = care_mask;
      cap_d  = '0;
      mis_d  = '0;
      pass_d = 1'b0;
    end else if (state_q == SAMPLE) begin
      cap_d[idx_q[N_IN-1:0]] = f_in;
      mis_d[idx_q[N_IN-1:0]] = sample_mis_w;
      if (last_w) begin
        // Verdict includes the final sample so it is valid alongside done.
        pass_d = ~|mis_d;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      idx_q  <= '0;
      exp_q  <= '0;
      care_q <= '0;
      cap_q  <= '0;
      mis_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      exp_q  <= exp_d;
      care_q <= care_d;
      cap_q  <= cap_d;
      mis_q  <= mis_d;
      pass_q <= pass_d;
    end
  end

`ifdef KMAP_SWEEP_FIRST_FAIL_EN
  logic            ff_vld_q, ff_vld_d;
  logic [N_IN-1:0] ff_idx_q, ff_idx_d;

  // First cared mismatch is recorded once and never overwritten in a sweep.
  always_comb begin
    ff_vld_d = ff_vld_q;
    ff_idx_d = ff_idx_q;
    if (accept_w) begin
      ff_vld_d = 1'b0;
      ff_idx_d = '0;
    end else if ((state_q == SAMPLE) && sample_mis_w && !ff_vld_q) begin
      ff_vld_d = 1'b1;
      ff_idx_d = idx_q[N_IN-1:0];
    end
  end

  // First-fail registers.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ff_vld_q <= 1'b0;
      ff_idx_q <= '0;
    end else begin
      ff_vld_q <= ff_vld_d;
      ff_idx_q <= ff_idx_d;
    end
  end

  assign first_fail_vld = ff_vld_q;
  assign first_fail_idx = ff_idx_q;
`endif

  // Moore outputs decoded from state plus held result registers.
  always_comb begin
    busy     = (state_q == SETTLE) || (state_q == SAMPLE);
    done     = (state_q == DONE);
    pass     = pass_q;
    x_out    = idx_q[N_IN-1:0];
    captured = cap_q;
    mismatch = mis_q;
  end

endmodule
`default_nettype wire
